// File: rtl/tt_um_drburke3_neuron_absdiff_accum_if.sv
// Pad-level bundle of the absolute-difference SAD tile.
// The bench drives it as master, and the tile consumes it as slave.
interface tt_um_drburke3_neuron_absdiff_accum_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input  uo_out, uio_out, uio_oe);
   modport slave  (input  ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_drburke3_neuron_absdiff_accum.sv
// Streaming |A-B| sum-of-absolute-differences accumulator built on a Sklansky prefix subtractor.
// Optional ABSDIFF_SAT_EN: the accumulator saturates and the overflow is reported through drop.
module tt_um_drburke3_neuron_absdiff_accum #(
   parameter int N_SAMPLES = 32,
   parameter int ACC_W     = 12
) (
   input  logic clk,
   input  logic rst_n,
   tt_um_drburke3_neuron_absdiff_accum_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HAVE_A = 3'd1,
      S_SUB    = 3'd2,
      S_ACC    = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

   // Position 0 of the prefix vector is the carry-in (g=1, p=0); positions 1..8 are operand bits 0..7.
   function automatic logic [8:0] sklansky_sub(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] g;
      logic [8:0] p;
      logic [7:0] nb;
      logic [7:0] hs;
      logic [8:0] d;
      int j;
      nb   = ~b;
      hs   = a ^ nb;
      g[0] = 1'b1;
      p[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         g[i+1] = a[i] & nb[i];
         p[i+1] = hs[i];
      end
      for (int l = 0; l < 4; l++) begin
         for (int i = 0; i < 9; i++) begin
            if (((i >> l) & 1) == 1) begin
               j    = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
               g[i] = g[i] | (p[i] & g[j]);
               p[i] = p[i] & p[j];
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         d[i] = hs[i] ^ g[i];
      end
      d[8] = g[8];
      return d;
   endfunction

   state_e            state_q, state_d;
   logic [7:0]        a_q, a_d, b_q, b_d, absd_q, absd_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ptr_q, ptr_d, drop_q, drop_d;
   logic [7:0]        uo_q, uo_d;
   logic [3:0]        flags_q, flags_d;
   logic [8:0]        diff_s;
   logic [7:0]        cnt_inc_s;
   logic [15:0]       acc_ext_s;
   logic              valid_s, sel_s, clear_s, rd_s, unused_s;
`ifdef ABSDIFF_SAT_EN
   logic [ACC_W:0]    sum_s;
`else
   logic [ACC_W-1:0]  sum_s;
`endif

   assign valid_s  = bus.uio_in[0];
   assign sel_s    = bus.uio_in[1];
   assign clear_s  = bus.uio_in[2];
   assign rd_s     = bus.uio_in[3];
   assign unused_s = ^bus.uio_in[7:4];

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      absd_d    = absd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      drop_d    = drop_q;
      diff_s    = sklansky_sub(a_q, b_q);
      cnt_inc_s = cnt_q + 8'd1;
`ifdef ABSDIFF_SAT_EN
      sum_s     = {1'b0, acc_q} + (ACC_W+1)'(absd_q);
`else
      sum_s     = acc_q + ACC_W'(absd_q);
`endif
      if (clear_s) begin
         // Clear beats any byte presented in the same cycle; the byte is simply lost.
         state_d = S_IDLE;
         a_d     = 8'h00;
         b_d     = 8'h00;
         acc_d   = '0;
         cnt_d   = 8'd0;
         ptr_d   = 1'b0;
         drop_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_s && !sel_s) begin
                  a_d     = bus.ui_in;
                  state_d = S_HAVE_A;
               end else if (valid_s) begin
                  drop_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HAVE_A: begin
               if (valid_s && !sel_s) begin
                  a_d = bus.ui_in;
               end else if (valid_s) begin
                  b_d     = bus.ui_in;
                  state_d = S_SUB;
               end else begin
                  state_d = S_HAVE_A;
               end
            end
            S_SUB: begin
               absd_d  = diff_s[8] ? diff_s[7:0] : (~diff_s[7:0] + 8'd1);
               state_d = S_ACC;
               if (valid_s) begin
                  drop_d = 1'b1;
               end else begin
                  drop_d = drop_q;
               end
            end
            S_ACC: begin
`ifdef ABSDIFF_SAT_EN
               if (sum_s[ACC_W]) begin
                  acc_d  = {ACC_W{1'b1}};
                  drop_d = 1'b1;
               end else begin
                  acc_d = sum_s[ACC_W-1:0];
               end
`else
               acc_d = sum_s;
`endif
               cnt_d = cnt_inc_s;
               if (valid_s) begin
                  drop_d = 1'b1;
               end else begin
                  drop_d = drop_d | 1'b0;
               end
               if (cnt_inc_s == N_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DONE: begin
               if (rd_s) begin
                  ptr_d = ~ptr_q;
               end else begin
                  ptr_d = ptr_q;
               end
               if (valid_s) begin
                  drop_d = 1'b1;
               end else begin
                  drop_d = drop_q;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      acc_ext_s               = 16'd0;
      acc_ext_s[ACC_W-1:0]    = acc_d;
      if (state_d == S_DONE) begin
         uo_d = ptr_d ? acc_ext_s[15:8] : acc_ext_s[7:0];
      end else begin
         uo_d = absd_d;
      end
      flags_d = {state_d == S_DONE, (state_d == S_SUB) || (state_d == S_ACC),
                 state_d == S_HAVE_A, drop_d};
   end

   // State, datapath and output registers; ena low freezes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         absd_q  <= 8'h00;
         acc_q   <= '0;
         cnt_q   <= 8'd0;
         ptr_q   <= 1'b0;
         drop_q  <= 1'b0;
         uo_q    <= 8'h00;
         flags_q <= 4'h0;
      end else if (bus.ena) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         absd_q  <= absd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         drop_q  <= drop_d;
         uo_q    <= uo_d;
         flags_q <= flags_d;
      end
   end

   assign bus.uo_out  = uo_q;
   assign bus.uio_out = {flags_q, 4'b0000};
   assign bus.uio_oe  = 8'hF0;
endmodule
